// File: rtl/srm_dma_arb_pkg.sv
// Shared definitions for the save-RAM copy engine: state encoding, RAM
// geometry and the engine-to-memory address mapping.
package srm_dma_arb_pkg;

  // The copy window covers PRG banks 0 and 1: 2 x 8 KB of PRG-RAM.
  localparam int RAM_BYTES = 16384;
  localparam int PTR_W     = $clog2(RAM_BYTES);
  localparam int LEN_W     = PTR_W + 1;
  localparam int BANK_BIT  = 13;
  localparam int ADDR_W    = 17;

  localparam logic DIR_DUMP    = 1'b0;
  localparam logic DIR_RESTORE = 1'b1;

  // Engine sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_XFER   = 3'd3,
    ST_DONE   = 3'd4
  } dma_state_t;

  // Stream handshakes (dat_out_*, dat_in_*): a byte moves on a rising clock
  // edge where valid and ready are both high. A raised valid holds, with its
  // data stable, until that edge. dat_in_rdy is only raised in the cycle the
  // engine starts a restore access, so it may depend on dat_in_vld.

  // Engine offset to PRG memory address: bit 13 picks bank 1, the upper
  // three address bits are always zero for banks 0-1.
  function automatic logic [ADDR_W-1:0] ram_addr(input logic [PTR_W-1:0] ptr);
    return {3'b000, ptr[BANK_BIT], ptr[BANK_BIT-1:0]};
  endfunction

endpackage

// File: rtl/srm_dma_arb_if.sv
// Bus bundle between the mapper/host side and the PRG-RAM arbiter.
interface srm_dma_arb_if;
  import srm_dma_arb_pkg::*;

  // Mapper PRG side
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ce;
  logic              cpu_oe;
  logic              cpu_we;
  logic [7:0]        cpu_din;
  // Physical PRG memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ce;
  logic              mem_oe;
  logic              mem_we;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  // Host command / status
  logic              cmd_start;
  logic              cmd_dir;
  logic [PTR_W-1:0]  cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy;
  logic              done;
  logic [15:0]       retry_cnt;
  // Dump and restore streams
  logic [7:0]        dat_out;
  logic              dat_out_vld;
  logic              dat_out_rdy;
  logic [7:0]        dat_in;
  logic              dat_in_vld;
  logic              dat_in_rdy;
  // Sequencer state, for observation
  dma_state_t        state;

  modport slave (
    input  cpu_addr, cpu_ce, cpu_oe, cpu_we, cpu_din, mem_din,
    input  cmd_start, cmd_dir, cmd_base, cmd_len, dat_out_rdy, dat_in, dat_in_vld,
    output mem_addr, mem_ce, mem_oe, mem_we, mem_dout,
    output busy, done, retry_cnt, dat_out, dat_out_vld, dat_in_rdy, state
  );

  modport master (
    output cpu_addr, cpu_ce, cpu_oe, cpu_we, cpu_din, mem_din,
    output cmd_start, cmd_dir, cmd_base, cmd_len, dat_out_rdy, dat_in, dat_in_vld,
    input  mem_addr, mem_ce, mem_oe, mem_we, mem_dout,
    input  busy, done, retry_cnt, dat_out, dat_out_vld, dat_in_rdy, state
  );

endinterface

// File: rtl/srm_dma_arb_m2_win_sync.sv
// Brings raw CPU M2 into the clk domain and times the M2-low window that
// the copy engine is allowed to use.
module m2_win_sync #(
  parameter int WIN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m2,
  output logic             m2_s,
  output logic             m2_fall,
  output logic             m2_rise,
  output logic [WIN_W-1:0] win
);

  logic m2_meta;
  logic m2_s_d;

  // Two-flop synchronizer plus one delay stage for edge detection; idles
  // high so reset never fakes a window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_meta <= 1'b1;
      m2_s    <= 1'b1;
      m2_s_d  <= 1'b1;
    end else begin
      m2_meta <= m2;
      m2_s    <= m2_meta;
      m2_s_d  <= m2_s;
    end
  end

  // Window offset: zero in the first synchronized-low clock, then counts up
  // and saturates while M2 stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (m2_s && !m2_meta) begin
      win <= '0;
    end else if (!m2_s && (win != '1)) begin
      win <= win + WIN_W'(1);
    end
  end

  assign m2_fall = m2_s_d & ~m2_s;
  assign m2_rise = ~m2_s_d & m2_s;

endmodule

// File: rtl/srm_dma_arb.sv
// PRG-RAM port arbiter: the CPU owns the port except for engine accesses
// squeezed into M2-low windows, which dump or restore a range of the 16 KB
// save RAM one byte per window.
module srm_dma_arb
  import srm_dma_arb_pkg::*;
#(
  parameter int ACC_CYC = 4,
  parameter int GUARD   = 2,
  parameter int WIN_MAX = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         m2,
  srm_dma_arb_if.slave bus
);

  localparam int WIN_W = $clog2(WIN_MAX + 2);
  localparam int CNT_W = $clog2(ACC_CYC + 1);
  localparam logic [WIN_W-1:0] GUARD_W   = WIN_W'(GUARD);
  localparam logic [WIN_W-1:0] WIN_MAX_W = WIN_W'(WIN_MAX);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACC_CYC - 1);

  logic             m2_s;
  logic             m2_fall;
  logic             m2_rise;
  logic [WIN_W-1:0] win;

  dma_state_t       state;
  dma_state_t       state_nx;
  logic [PTR_W-1:0] ptr;
  logic [LEN_W-1:0] rem;
  logic             dir;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_done;
  logic [7:0]       hold_byte;
  logic             hold_vld;
  logic [7:0]       out_byte;
  logic             out_vld;
  logic             done_seen;
  logic [15:0]      retry_q;

  logic             acc_last;
  logic             data_ok;
  logic             start_ok;
  logic             take_in;
  logic             done_o;
  logic             eng_on;

  m2_win_sync #(.WIN_W(WIN_W)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .m2      (m2),
    .m2_s    (m2_s),
    .m2_fall (m2_fall),
    .m2_rise (m2_rise),
    .win     (win)
  );

  assign acc_last = (acc_cnt == ACC_LAST);
  assign data_ok  = dir ? (hold_vld || bus.dat_in_vld) : !out_vld;
  assign start_ok = !m2_s && (win >= GUARD_W) && (win <= WIN_MAX_W) && !acc_done && data_ok;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state, restore-byte acceptance and done pulse.
  always_comb begin
    state_nx = state;
    take_in  = 1'b0;
    done_o   = 1'b0;
    case (state)
      ST_IDLE:   if (bus.cmd_start) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (start_ok) begin
          state_nx = ST_ACCESS;
          take_in  = dir && !hold_vld;
        end
      end
      ST_ACCESS: begin
        if (m2_rise)       state_nx = ST_WAIT;
        else if (acc_last) state_nx = ST_XFER;
      end
      ST_XFER:   state_nx = (rem == LEN_W'(1)) ? ST_DONE : ST_WAIT;
      ST_DONE: begin
        done_o = !done_seen;
        if (!out_vld) state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Transfer bookkeeping: command latch, access timing, data registers and
  // the abort counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      rem       <= '0;
      dir       <= DIR_DUMP;
      acc_cnt   <= '0;
      acc_done  <= 1'b0;
      hold_byte <= '0;
      hold_vld  <= 1'b0;
      out_byte  <= '0;
      out_vld   <= 1'b0;
      done_seen <= 1'b0;
      retry_q   <= '0;
    end else begin
      done_seen <= (state == ST_DONE);
      acc_cnt   <= (state == ST_ACCESS && !acc_last) ? acc_cnt + CNT_W'(1) : '0;

      if (m2_fall) acc_done <= 1'b0;
      else if (state == ST_ACCESS && acc_last && !m2_rise) acc_done <= 1'b1;

      if (out_vld && bus.dat_out_rdy) out_vld <= 1'b0;

      if (state == ST_IDLE && bus.cmd_start) begin
        dir      <= bus.cmd_dir;
        ptr      <= bus.cmd_base;
        rem      <= (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
        hold_vld <= 1'b0;
      end

      if (take_in) begin
        hold_byte <= bus.dat_in;
        hold_vld  <= 1'b1;
      end

      // An aborted access keeps ptr and any held restore byte for the retry.
      if (state == ST_ACCESS && m2_rise) begin
        if (retry_q != 16'hFFFF) retry_q <= retry_q + 16'd1;
      end else if (state == ST_ACCESS && acc_last && dir == DIR_DUMP) begin
        out_byte <= bus.mem_din;
        out_vld  <= 1'b1;
      end

      if (state == ST_XFER) begin
        ptr      <= ptr + PTR_W'(1);
        rem      <= rem - LEN_W'(1);
        hold_vld <= 1'b0;
      end
    end
  end

  assign eng_on = (state == ST_ACCESS) && !m2_s;

  // Memory port mux: the CPU path wins whenever the engine is not mid-access
  // inside a low M2 window.
  always_comb begin
    bus.mem_addr = bus.cpu_addr;
    bus.mem_ce   = bus.cpu_ce;
    bus.mem_oe   = bus.cpu_oe;
    bus.mem_we   = bus.cpu_we;
    bus.mem_dout = bus.cpu_din;
    if (eng_on) begin
      bus.mem_addr = ram_addr(ptr);
      bus.mem_ce   = 1'b1;
      bus.mem_oe   = (dir == DIR_DUMP);
      bus.mem_we   = (dir == DIR_RESTORE);
      bus.mem_dout = hold_byte;
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done_o;
  assign bus.dat_out     = out_byte;
  assign bus.dat_out_vld = out_vld;
  assign bus.dat_in_rdy  = take_in;
  assign bus.retry_cnt   = retry_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_srm_dma_arb.sv
// Directed bench for srm_dma_arb: a PRG-RAM model, an M2 window generator
// and stream driver/collector around a linear sequence of steps.
module tb_srm_dma_arb;
  import srm_dma_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m2 = 1'b1;
  always #5 clk = ~clk;

  srm_dma_arb_if bus ();

  srm_dma_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m2    (m2),
    .bus   (bus)
  );

  int tests_n = 0;
  int fail_n  = 0;

  // ---------------- PRG memory model ----------------
  logic [7:0] mem_model [0:131071];
  assign bus.mem_din = (bus.mem_ce && bus.mem_oe) ? mem_model[bus.mem_addr] : 8'h00;
  always @(posedge clk) begin
    if (bus.mem_ce && bus.mem_we) mem_model[bus.mem_addr] = bus.mem_dout;
  end

  // ---------------- restore stream driver ----------------
  logic [7:0] in_q[$];
  bit hs_pend = 1'b0;
  always @(negedge clk) begin
    if (hs_pend && in_q.size() > 0) void'(in_q.pop_front());
    hs_pend = 1'b0;
    if (in_q.size() > 0) begin
      bus.dat_in     = in_q[0];
      bus.dat_in_vld = 1'b1;
    end else begin
      bus.dat_in     = 8'h00;
      bus.dat_in_vld = 1'b0;
    end
    #1 hs_pend = bus.dat_in_vld && bus.dat_in_rdy;
  end

  // ---------------- monitors ----------------
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [16:0] addr_q[$];
  int acc_n  = 0;
  int done_n = 0;
  bit eng_prev = 1'b0;
  always @(negedge clk) begin
    #1;
    if (bus.dat_out_vld && bus.dat_out_rdy) got_q.push_back(bus.dat_out);
    if (bus.done) done_n++;
    if (bus.mem_ce && !bus.cpu_ce && !eng_prev) begin
      acc_n++;
      addr_q.push_back(bus.mem_addr);
    end
    eng_prev = bus.mem_ce && !bus.cpu_ce;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check({tag, "_byte"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic d, input logic [13:0] base, input logic [14:0] len);
    bus.cmd_dir   = d;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
  endtask

  // One M2 cycle: low for low_n clocks, then high; optionally a CPU read
  // during the high phase that must reach memory untouched.
  task automatic m2_win(input int low_n, input int high_n, input bit cpu_chk, input logic [16:0] chk_addr);
    m2 = 1'b0;
    repeat (low_n) @(negedge clk);
    m2 = 1'b1;
    if (cpu_chk) begin
      repeat (3) @(negedge clk);
      bus.cpu_addr = chk_addr;
      bus.cpu_ce   = 1'b1;
      bus.cpu_oe   = 1'b1;
      #1 check("cpu_read_path", 32'({bus.mem_ce, bus.mem_oe, bus.mem_we, bus.mem_addr}),
               32'({3'b110, chk_addr}));
      @(negedge clk);
      bus.cpu_ce = 1'b0;
      bus.cpu_oe = 1'b0;
      repeat (high_n - 4) @(negedge clk);
    end else begin
      repeat (high_n) @(negedge clk);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    fail_n++;
    $display("[TB] %0d tests run, %0d failed", tests_n, fail_n);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    bit reached;
    for (int i = 0; i < 131072; i++) mem_model[i] = 8'h00;
    bus.cpu_addr = 17'h06123; bus.cpu_ce = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_we = 1'b0;
    bus.cpu_din = 8'h00; bus.cmd_start = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_base = '0;
    bus.cmd_len = '0; bus.dat_out_rdy = 1'b1;

    // Reset state: strobes follow the CPU
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_out_vld", 32'(bus.dat_out_vld), 32'd0);
    check("rst_in_rdy", 32'(bus.dat_in_rdy), 32'd0);
    check("rst_retry", 32'(bus.retry_cnt), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst_mem_path", 32'({bus.mem_ce, bus.mem_oe, bus.mem_we, bus.mem_addr}), 32'({3'b110, 17'h06123}));
    rst_n = 1'b1;
    bus.cpu_ce = 1'b0; bus.cpu_oe = 1'b0;
    repeat (5) @(negedge clk);

    // Dump base 0 len 4
    mem_model[0] = 8'h11; mem_model[1] = 8'h12; mem_model[2] = 8'h13; mem_model[3] = 8'h14;
    start_cmd(1'b0, 14'h0000, 15'd4);
    check("dump_busy", 32'(bus.busy), 32'd1);
    for (int w = 0; w < 3; w++) m2_win(28, 28, 1'b1, 17'h00003);
    check("dump_done_early", 32'(done_n), 32'd0);
    m2_win(28, 28, 1'b1, 17'h00003);
    check("dump_done", 32'(done_n), 32'd1);
    check("dump_idle", 32'(bus.busy), 32'd0);
    check("dump_accesses", 32'(acc_n), 32'd4);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    cmp_stream("dump4");

    // Length 0 behaves as 1
    start_cmd(1'b0, 14'h0001, 15'd0);
    m2_win(28, 28, 1'b0, '0);
    m2_win(28, 28, 1'b0, '0);
    check("len0_done", 32'(done_n), 32'd2);
    exp_q = '{8'h12};
    cmp_stream("len0");

    // Restore into bank 1
    in_q.push_back(8'hA5); in_q.push_back(8'h5A);
    start_cmd(1'b1, 14'h2000, 15'd2);
    m2_win(28, 28, 1'b0, '0);
    m2_win(28, 28, 1'b0, '0);
    check("rest_b1_0", 32'(mem_model[17'h02000]), 32'hA5);
    check("rest_b1_1", 32'(mem_model[17'h02001]), 32'h5A);
    check("rest_done", 32'(done_n), 32'd3);
    check("rest_in_drained", 32'(in_q.size()), 32'd0);

    // Dump across the 16 KB wrap
    mem_model[17'h03FFF] = 8'h77;
    addr_q.delete();
    start_cmd(1'b0, 14'h3FFF, 15'd2);
    m2_win(28, 28, 1'b0, '0);
    m2_win(28, 28, 1'b0, '0);
    check("wrap_addr0", 32'(addr_q[0]), 32'h03FFF);
    check("wrap_addr1", 32'(addr_q[1]), 32'h00000);
    exp_q = '{8'h77, 8'h11};
    cmp_stream("wrap");

    // Short M2 low: rise lands mid-access, retried at same address
    mem_model[17'h00100] = 8'hC3; mem_model[17'h00101] = 8'h3C;
    addr_q.delete();
    start_cmd(1'b0, 14'h0100, 15'd2);
    m2_win(5, 28, 1'b0, '0);
    check("abort_retry", 32'(bus.retry_cnt), 32'd1);
    check("abort_no_byte", 32'(got_q.size()), 32'd0);
    m2_win(28, 28, 1'b0, '0);
    m2_win(28, 28, 1'b0, '0);
    check("abort_addr_n", 32'(addr_q.size()), 32'd3);
    check("abort_addr0", 32'(addr_q[0]), 32'h00100);
    check("abort_addr1", 32'(addr_q[1]), 32'h00100);
    check("abort_addr2", 32'(addr_q[2]), 32'h00101);
    check("abort_done", 32'(done_n), 32'd5);
    exp_q = '{8'hC3, 8'h3C};
    cmp_stream("abort");

    // Back-pressure: no further accesses while the output byte is unread
    mem_model[17'h00200] = 8'hD0; mem_model[17'h00201] = 8'hD1; mem_model[17'h00202] = 8'hD2;
    bus.dat_out_rdy = 1'b0;
    d0 = acc_n;
    start_cmd(1'b0, 14'h0200, 15'd3);
    for (int w = 0; w < 10; w++) begin
      if (w == 4) start_cmd(1'b0, 14'h0300, 15'd5);
      m2_win(28, 28, 1'b0, '0);
    end
    check("stall_accesses", 32'(acc_n - d0), 32'd1);
    check("stall_vld", 32'(bus.dat_out_vld), 32'd1);
    check("stall_byte", 32'(bus.dat_out), 32'hD0);
    check("stall_busy", 32'(bus.busy), 32'd1);
    bus.dat_out_rdy = 1'b1;
    for (int w = 0; w < 3; w++) m2_win(28, 28, 1'b0, '0);
    check("stall_accesses_end", 32'(acc_n - d0), 32'd3);
    check("stall_done", 32'(done_n), 32'd6);
    exp_q = '{8'hD0, 8'hD1, 8'hD2};
    cmp_stream("stall");

    // Reset in the middle of a restore access
    in_q.push_back(8'h99); in_q.push_back(8'h98);
    start_cmd(1'b1, 14'h0500, 15'd2);
    m2_win(28, 28, 1'b0, '0);
    check("rstmid_first", 32'(mem_model[17'h00500]), 32'h99);
    d0 = done_n;
    m2 = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      @(negedge clk);
      #1 reached = (bus.state == ST_ACCESS) && bus.mem_ce;
    end
    check("rstmid_access_seen", 32'(reached), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_strobes", 32'({bus.mem_ce, bus.mem_oe, bus.mem_we}), 32'({bus.cpu_ce, bus.cpu_oe, bus.cpu_we}));
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_state", 32'(bus.state), 32'(ST_IDLE));
    @(negedge clk);
    in_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    m2 = 1'b1;
    repeat (20) @(negedge clk);
    check("rstmid_no_done", 32'(done_n), 32'(d0));
    check("rstmid_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_n, fail_n);
    $finish;
  end

endmodule
